// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its surroundings (controller,
// instruction ROM, opcode decoder, ALU). The sequencer uses the slave modport;
// whatever drives start and the decoded instruction fields uses master.
interface instr_sequencer_if #(
  parameter int PC_W = 10
);
  // Run control handshake
  logic            start;
  logic            done;
  logic            busy;
  logic            timeout;
  // Fields of the fetched instruction, as seen by the sequencer
  logic [2:0]      instr_op;
  logic [2:0]      instr_type;
  logic            branch;
  logic            branch_cond;
  logic [PC_W-1:0] branch_target;
  logic            mem_access;
  // Fetch address and stage enables
  logic [PC_W-1:0] prog_ctr;
  logic            fetch_en;
  logic            exec_en;

  modport master (
    output start, instr_op, instr_type, branch, branch_cond, branch_target, mem_access,
    input  prog_ctr, fetch_en, exec_en, busy, done, timeout
  );

  modport slave (
    input  start, instr_op, instr_type, branch, branch_cond, branch_target, mem_access,
    output prog_ctr, fetch_en, exec_en, busy, done, timeout
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 8-bit core. Owns the program
// counter, issues fetch_en for one cycle per instruction and exec_en on the
// single commit cycle of each instruction, and stops on the HALT encoding.
// Optional feature: define SEQ_WATCHDOG_EN to add a run-length watchdog that
// ends a run after WD_LIMIT busy cycles and flags it on timeout.
module instr_sequencer #(
  parameter int PC_W     = 10,
  parameter int START_PC = 0,
  parameter int MEM_LAT  = 2,
  parameter int WD_LIMIT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int              LAT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
  localparam logic [PC_W-1:0]  START_PC_V = PC_W'(START_PC);

  // Reject configurations the counters cannot represent
  if (MEM_LAT < 1 || WD_LIMIT < 2) begin : g_cfg_check
    $error("instr_sequencer: MEM_LAT must be >= 1 and WD_LIMIT >= 2");
  end

  state_e            state_q, state_d;
  logic [PC_W-1:0]   prog_ctr_q, prog_ctr_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              is_halt;
  logic              mem_last;
  logic              start_ok;
  logic              busy_w;
  logic              wd_fire;
  logic              exec_en_w;

  assign is_halt  = (bus.instr_op == 3'b111) && (bus.instr_type == 3'b111);
  assign mem_last = (lat_cnt_q == LAT_LAST);
  assign busy_w   = (state_q == S_FETCH) || (state_q == S_EXEC);

  // Next-state, program counter and memory-latency counter
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    prog_ctr_d = prog_ctr_q;
    lat_cnt_d  = lat_cnt_q;
    start_ok   = 1'b0;
    exec_en_w  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_ok   = 1'b1;
          state_d    = S_FETCH;
          prog_ctr_d = START_PC_V;
        end
      end
      S_FETCH: begin
        lat_cnt_d = '0;
        state_d   = wd_fire ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        if (wd_fire || is_halt) begin
          // Abandon without committing; prog_ctr keeps pointing at the stopping instruction
          state_d = S_DONE;
        end else if (bus.mem_access && !mem_last) begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end else begin
          exec_en_w  = 1'b1;
          prog_ctr_d = (bus.branch && bus.branch_cond) ? bus.branch_target
                                                       : prog_ctr_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, program counter and latency counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prog_ctr_q <= START_PC_V;
      lat_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      prog_ctr_q <= prog_ctr_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int               WD_W    = (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WD_LIMIT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  assign wd_fire = busy_w && (wd_cnt_q == WD_LAST);

  // Watchdog count of busy cycles since the last accepted start
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (start_ok) begin
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (busy_w) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_fire) timeout_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.prog_ctr = prog_ctr_q;
  assign bus.fetch_en = (state_q == S_FETCH);
  assign bus.busy     = busy_w;
  assign bus.done     = (state_q == S_DONE);
  assign bus.exec_en  = exec_en_w;

endmodule
